char_text_buffer: RTL and testbench

Character-code store and font-address server for the `char_display` overlay stage. It answers that stage's `char_xy`/`char_line` lookups with font pixels, using a 256-entry character RAM and an external font ROM. Game logic fills the RAM through a single-char write port and a decimal-number writer FSM (scores, timers). A clear engine fills the RAM with spaces after reset and on request.

---
 rtl/char_text_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_char_text_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_text_buffer.sv
// Character RAM and font-address server for the char_display overlay, with a
// clear engine and a decimal number writer. Optional: TEXT_BUF_LEADING_ZERO_BLANK_EN.
module char_text_buffer #(
  parameter logic [6:0] SPACE_CODE = 7'h20,
  parameter logic [6:0] DIGIT_BASE = 7'h30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  char_xy,
  input  logic [3:0]  char_line,
  output logic [7:0]  char_pixels,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_pixels,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_xy,
  input  logic [6:0]  wr_char,
  input  logic        num_valid,
  output logic        num_ready,
  input  logic [7:0]  num_xy,
  input  logic [13:0] num_value,
  input  logic        clr_req,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CONV  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t          state_r;
  logic [7:0]      clr_cnt_r;
  logic [7:0]      num_xy_r;
  logic [13:0]     rem_r;
  logic [3:0][3:0] digit_r;
  logic [1:0]      weight_idx_r;
  logic [1:0]      wr_idx_r;
  logic            busy_r;
  logic            idle_r;

  logic [6:0]      ram [0:255];

  logic            ram_we_s;
  logic [7:0]      ram_addr_s;
  logic [6:0]      ram_data_s;
  logic [13:0]     weight_s;
  logic [1:0]      digit_sel_s;
  logic [3:0]      wr_digit_s;
  logic            blank_s;
  logic [13:0]     num_sat_s;

  function automatic logic [13:0] weight_of(input logic [1:0] idx);
    case (idx)
      2'd0:    weight_of = 14'd1000;
      2'd1:    weight_of = 14'd100;
      2'd2:    weight_of = 14'd10;
      default: weight_of = 14'd1;
    endcase
  endfunction

`ifdef TEXT_BUF_LEADING_ZERO_BLANK_EN
  // A digit is blanked while every more-significant digit is also zero; d0 never is.
  function automatic logic lead_blank(input logic [3:0][3:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    lead_blank = (d[3] == 4'd0);
      2'd1:    lead_blank = (d[3] == 4'd0) && (d[2] == 4'd0);
      2'd2:    lead_blank = (d[3] == 4'd0) && (d[2] == 4'd0) && (d[1] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
  endfunction
`endif

  // Converter helpers: current weight, target digit, saturated input, digit being written
  always_comb begin
    weight_s    = weight_of(weight_idx_r);
    digit_sel_s = 2'd3 - weight_idx_r;
    wr_digit_s  = digit_r[2'd3 - wr_idx_r];
    if (num_value > 14'd9999) begin
      num_sat_s = 14'd9999;
    end else begin
      num_sat_s = num_value;
    end
`ifdef TEXT_BUF_LEADING_ZERO_BLANK_EN
    blank_s = lead_blank(digit_r, wr_idx_r);
`else
    blank_s = 1'b0;
`endif
  end

  // Single RAM write port shared by clear engine, char writes and digit writes
  always_comb begin
    ram_we_s   = 1'b0;
    ram_addr_s = 8'd0;
    ram_data_s = 7'd0;
    case (state_r)
      ST_CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_cnt_r;
        ram_data_s = SPACE_CODE;
      end
      ST_IDLE: begin
        if (wr_valid && !num_valid) begin
          ram_we_s   = 1'b1;
          ram_addr_s = wr_xy;
          ram_data_s = wr_char;
        end else begin
          ram_we_s   = 1'b0;
        end
      end
      ST_WRITE: begin
        ram_we_s   = 1'b1;
        ram_addr_s = {num_xy_r[7:4], num_xy_r[3:0] + {2'b00, wr_idx_r}};
        if (blank_s) begin
          ram_data_s = SPACE_CODE;
        end else begin
          ram_data_s = DIGIT_BASE + {3'b000, wr_digit_s};
        end
      end
      default: begin
        ram_we_s   = 1'b0;
      end
    endcase
  end

  // Character RAM storage; deliberately not reset, the clear engine fills it
  always_ff @(posedge pclk) begin
    if (ram_we_s) begin
      ram[ram_addr_s] <= ram_data_s;
    end
  end

  // Control FSM; busy/idle flags are registered alongside every state change
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_CLEAR;
      clr_cnt_r    <= 8'd0;
      num_xy_r     <= 8'd0;
      rem_r        <= 14'd0;
      digit_r      <= '0;
      weight_idx_r <= 2'd0;
      wr_idx_r     <= 2'd0;
      busy_r       <= 1'b1;
      idle_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + 8'd1;
          if (clr_cnt_r == 8'hFF) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            idle_r  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (num_valid) begin
            num_xy_r     <= num_xy;
            rem_r        <= num_sat_s;
            digit_r      <= '0;
            weight_idx_r <= 2'd0;
            wr_idx_r     <= 2'd0;
            state_r      <= ST_CONV;
            busy_r       <= 1'b1;
            idle_r       <= 1'b0;
          end
        end
        ST_CONV: begin
          if (rem_r >= weight_s) begin
            rem_r                <= rem_r - weight_s;
            digit_r[digit_sel_s] <= digit_r[digit_sel_s] + 4'd1;
          end else if (weight_idx_r == 2'd3) begin
            wr_idx_r <= 2'd0;
            state_r  <= ST_WRITE;
          end else begin
            weight_idx_r <= weight_idx_r + 2'd1;
          end
        end
        ST_WRITE: begin
          wr_idx_r <= wr_idx_r + 2'd1;
          if (wr_idx_r == 2'd3) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            idle_r  <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= 8'd0;
          busy_r    <= 1'b1;
          idle_r    <= 1'b0;
        end
      endcase
      // A clear request overrides whatever the state logic chose above.
      if (clr_req) begin
        state_r   <= ST_CLEAR;
        clr_cnt_r <= 8'd0;
        busy_r    <= 1'b1;
        idle_r    <= 1'b0;
      end
    end
  end

  assign busy        = busy_r;
  assign num_ready   = idle_r;
  assign wr_ready    = idle_r & ~num_valid;
  assign font_addr   = {ram[char_xy], char_line};
  assign char_pixels = font_pixels;

endmodule

// File: tb/tb_char_text_buffer.sv
// Randomized scoreboard bench for char_text_buffer: stimulus queues expectations,
// a negedge monitor pops and compares lookups and busy-run lengths.
module tb_char_text_buffer;

  localparam logic [6:0] SPACE  = 7'h20;
  localparam logic [6:0] DIGIT0 = 7'h30;

  logic        pclk = 1'b0;
  logic        rst;
  logic [7:0]  char_xy = 8'd0;
  logic [3:0]  char_line = 4'd0;
  logic [7:0]  char_pixels;
  logic [10:0] font_addr;
  logic [7:0]  font_pixels;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_xy = 8'd0;
  logic [6:0]  wr_char = 7'd0;
  logic        num_valid = 1'b0;
  logic        num_ready;
  logic [7:0]  num_xy = 8'd0;
  logic [13:0] num_value = 14'd0;
  logic        clr_req = 1'b0;
  logic        busy;

  char_text_buffer dut (
    .pclk(pclk), .rst(rst),
    .char_xy(char_xy), .char_line(char_line),
    .char_pixels(char_pixels), .font_addr(font_addr), .font_pixels(font_pixels),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_xy(wr_xy), .wr_char(wr_char),
    .num_valid(num_valid), .num_ready(num_ready), .num_xy(num_xy), .num_value(num_value),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // Stand-in font ROM: any fixed function of the address.
  function automatic logic [7:0] rom(input logic [10:0] a);
    return a[10:3] ^ {a[3:0], a[7:4]};
  endfunction
  assign font_pixels = rom(font_addr);

  typedef struct {
    string       name;
    logic [10:0] addr;
    bit          chk_addr;
    bit          chk_rdy;
    bit          wr_rdy;
    bit          num_rdy;
    bit          bsy;
  } probe_t;

  probe_t     probe_q[$];
  int         lat_q[$];
  logic [6:0] model [256];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         probe_v = 1'b0;
  int         run = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: busy-run lengths against queued latencies, probes against queued lookups
  always @(negedge pclk) begin
    probe_t p;
    if (rst) begin
      run = 0;
    end else if (busy === 1'b1) begin
      run++;
    end else if (run != 0) begin
      if (lat_q.size() == 0) check("busy_run_unexpected", run, 0);
      else check("busy_run", run, lat_q.pop_front());
      run = 0;
    end
    if (probe_v) begin
      if (probe_q.size() == 0) begin
        check("probe_queue", probe_q.size(), 1);
      end else begin
        p = probe_q.pop_front();
        if (p.chk_addr) begin
          check({p.name, "_font_addr"}, font_addr, p.addr);
          check({p.name, "_pixels"}, char_pixels, rom(p.addr));
        end
        if (p.chk_rdy) begin
          check({p.name, "_wr_ready"}, wr_ready, p.wr_rdy);
          check({p.name, "_num_ready"}, num_ready, p.num_rdy);
          check({p.name, "_busy"}, busy, p.bsy);
        end
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_probe(input logic [7:0] xy, input logic [3:0] line, input string nm,
                            input bit chk_addr, input bit chk_rdy, input bit wr_rdy,
                            input bit num_rdy, input bit bsy);
    probe_t p;
    char_xy    = xy;
    char_line  = line;
    p.name     = nm;
    p.addr     = {model[xy], line};
    p.chk_addr = chk_addr;
    p.chk_rdy  = chk_rdy;
    p.wr_rdy   = wr_rdy;
    p.num_rdy  = num_rdy;
    p.bsy      = bsy;
    probe_q.push_back(p);
    probe_v = 1'b1;
  endtask

  task automatic probe_a(input logic [7:0] xy, input logic [3:0] line, input string nm);
    push_probe(xy, line, nm, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    probe_v = 1'b0;
  endtask

  task automatic sweep(input string nm);
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      probe_a(a, a[3:0], nm);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = SPACE;
  endtask

  // Reference: decimal text of the saturated value, wrapping within the row.
  function automatic int apply_num(input logic [7:0] xy, input int v);
    int pw[4] = '{1000, 100, 10, 1};
    int sv;
    int lat;
    sv  = (v > 9999) ? 9999 : v;
    lat = 8;
    for (int i = 0; i < 4; i++) begin
      int d;
      logic [6:0] code;
      logic [3:0] col;
      d    = (sv / pw[i]) % 10;
      lat += d;
      code = DIGIT0 + 7'(d);
`ifdef TEXT_BUF_LEADING_ZERO_BLANK_EN
      if (i < 3 && sv < pw[i]) code = SPACE;
`endif
      col = xy[3:0] + 4'(i);
      model[{xy[7:4], col}] = code;
    end
    return lat;
  endfunction

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (num_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (num_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: num_ready=%b after %0d cycles, required 1", nm, num_ready, n);
    end
  endtask

  task automatic do_num(input logic [7:0] xy, input int v, input string nm);
    wait_idle(400, nm);
    num_xy    = xy;
    num_value = 14'(v);
    num_valid = 1'b1;
    lat_q.push_back(apply_num(xy, v));
    step();
    num_valid = 1'b0;
    wait_idle(100, nm);
  endtask

  task automatic do_char(input logic [7:0] xy, input logic [6:0] c);
    wait_idle(400, "char");
    wr_xy    = xy;
    wr_char  = c;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    model[xy] = c;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    step();
    step();
    push_probe(8'h00, 4'h0, "reset_state", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    probe_v = 1'b0;

    // Release: clear takes exactly 256 cycles, then every cell is a space.
    lat_q.push_back(256);
    rst = 1'b0;
    wait_idle(400, "reset_clear");
    sweep("clear");

    // Char write: old code visible before the edge, new code after.
    wr_valid = 1'b1;
    wr_xy    = 8'h12;
    wr_char  = 7'h41;
    push_probe(8'h12, 4'h5, "pre_write", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    probe_v  = 1'b0;
    wr_valid = 1'b0;
    model[8'h12] = 7'h41;
    probe_a(8'h12, 4'h5, "post_write");

    do_num(8'h0C, 1234, "num1234");
    for (int i = 0; i < 8; i++) probe_a(8'h0C + 8'(i), 4'(i), "num1234");
    do_num(8'h50, 12000, "num_sat");
    for (int i = 0; i < 4; i++) probe_a(8'h50 + 8'(i), 4'h7, "num_sat");
    do_num(8'h3E, 42, "num42");
    probe_a(8'h3E, 4'h1, "num42");
    probe_a(8'h3F, 4'h2, "num42");
    probe_a(8'h30, 4'h3, "num42");
    probe_a(8'h31, 4'h4, "num42");

    // Contention: number wins, char write refused in the same cycle.
    wait_idle(400, "contend");
    num_xy    = 8'h70;
    num_value = 14'd7;
    num_valid = 1'b1;
    wr_xy     = 8'h80;
    wr_char   = 7'h5A;
    wr_valid  = 1'b1;
    lat_q.push_back(apply_num(8'h70, 7));
    push_probe(8'h80, 4'h3, "contend", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    probe_v   = 1'b0;
    num_valid = 1'b0;
    wr_valid  = 1'b0;
    wait_idle(100, "contend");
    probe_a(8'h80, 4'h3, "contend_char");
    for (int i = 0; i < 4; i++) probe_a(8'h70 + 8'(i), 4'h9, "contend_num");

    // Clear pulse during CONV: busy until 256 cycles after the pulse edge.
    wait_idle(400, "clr_abort");
    num_xy    = 8'h90;
    num_value = 14'd9876;
    num_valid = 1'b1;
    step();
    num_valid = 1'b0;
    repeat (5) step();
    clr_req = 1'b1;
    lat_q.push_back(5 + 1 + 256);
    step();
    clr_req = 1'b0;
    wait_idle(400, "clr_abort");
    model_clear();
    sweep("clr_abort");

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: do_char(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
        1: do_num(8'($urandom_range(0, 255)), int'($urandom_range(0, 16383)), "rand_num");
        default: begin
          wait_idle(400, "rand_probe");
          for (int k = 0; k < 4; k++) begin
            a = 8'($urandom_range(0, 255));
            probe_a(a, 4'($urandom_range(0, 15)), "rand_probe");
          end
        end
      endcase
    end
    wait_idle(400, "rand_final");
    sweep("rand_final");

    // Reset mid-operation restarts the clear from address 0.
    num_xy    = 8'hA0;
    num_value = 14'd5555;
    num_valid = 1'b1;
    step();
    num_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    lat_q.push_back(256);
    rst = 1'b0;
    wait_idle(400, "mid_reset");
    model_clear();
    for (int k = 0; k < 16; k++) begin
      a = 8'($urandom_range(0, 255));
      probe_a(a, a[7:4], "mid_reset");
    end

    step();
    step();
    step();
    check("lat_queue_drained", lat_q.size(), 0);
    check("probe_queue_drained", probe_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
